// File: rtl/div_ctrl_pkg.sv
// Shared CPU definitions for the divide controller: FSM encoding, EX divide op codes
// and the default abort limit for a divide that never completes.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StWb    = 2'd3
  } div_state_e;

  typedef enum logic [1:0] {
    DivOpNone = 2'b00,
    DivOpDiv  = 2'b01,
    DivOpDivu = 2'b10,
    DivOpRsvd = 2'b11
  } div_op_e;

  localparam int unsigned DivTimeoutDflt = 40;

  // Reserved encoding 11 behaves as "no divide".
  function automatic logic is_div_op(logic [1:0] op);
    return (op == DivOpDiv) || (op == DivOpDivu);
  endfunction

endpackage

// File: rtl/div_ctrl.sv
// EX-stage controller for an external iterative divider: launches DIV/DIVU, stalls EX,
// writes HI/LO on completion and drains or aborts cancelled/hung operations.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DivTimeoutDflt
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [1:0]  ex_div_op,
  input  logic        ex_hilo_rd,
  input  logic [31:0] ex_x,
  input  logic [31:0] ex_y,
  input  logic        ex_flush,
  output logic        ex_stall,
  output logic        du_go,
  output logic        du_signed,
  output logic [31:0] du_x,
  output logic [31:0] du_y,
  input  logic [31:0] du_s,
  input  logic [31:0] du_r,
  input  logic        du_done,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        busy,
  output logic        err
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  div_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            start;
  logic            timeout_hit;

  always_comb begin
    start       = (state_q == StIdle) && ex_valid && is_div_op(ex_div_op) && !ex_flush;
    timeout_hit = (cnt_q == CntLast);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      du_go     <= 1'b0;
      du_signed <= 1'b0;
      du_x      <= '0;
      du_y      <= '0;
      hi_wdata  <= '0;
      lo_wdata  <= '0;
      err       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StRun;
            cnt_q     <= '0;
            du_go     <= 1'b1;
            du_signed <= (ex_div_op == DivOpDiv);
            du_x      <= ex_x;
            du_y      <= ex_y;
          end
        end
        StRun, StDrain: begin
          if (du_done) begin
            du_go <= 1'b0;
            // A flush landing on the done cycle discards the result outright.
            if ((state_q == StRun) && !ex_flush) begin
              lo_wdata <= du_s;
              hi_wdata <= du_r;
              state_q  <= StWb;
            end else begin
              state_q <= StIdle;
            end
          end else if (timeout_hit) begin
            du_go   <= 1'b0;
            err     <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
            if ((state_q == StRun) && ex_flush) begin
              state_q <= StDrain;
            end
          end
        end
        StWb: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // The write strobe is gated late so an exception in the WB cycle can still cancel it.
  always_comb begin
    hi_we = (state_q == StWb) && !ex_flush;
    lo_we = hi_we;
    busy  = (state_q != StIdle);
  end

  always_comb begin
    ex_stall = 1'b0;
    unique case (state_q)
      StIdle:  ex_stall = start;
      StRun:   ex_stall = 1'b1;
      StDrain: ex_stall = ex_valid && ((ex_div_op != DivOpNone) || ex_hilo_rd);
      StWb:    ex_stall = 1'b0;
      default: ex_stall = 1'b0;
    endcase
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, meaning the maximum number of cycles in RUN or DRAIN before abort.
REQ-002 SHALL have one clock and a reset that is synchronous and active-high: clk  in  1  clock.
REQ-003 SHALL have: reset  in  1  synchronous active-high reset.
REQ-004 SHALL have: ex_valid  in  1  EX stage holds a valid instruction.
REQ-005 SHALL have: ex_div_op  in  2  00 none, 01 DIV (signed), 10 DIVU, 11 reserved (treated as none).
REQ-006 SHALL have: ex_hilo_rd  in  1  EX instruction reads HI/LO (MFHI/MFLO).
REQ-007 SHALL have: ex_x, ex_y  in  32 each  dividend and divisor.
REQ-008 SHALL have: ex_flush  in  1  cancel the EX instruction (exception/ERET).
REQ-009 SHALL have: ex_stall  out  1  hold the EX stage.
REQ-010 SHALL have: du_go  out  1  level request to the iterative divider.
REQ-011 SHALL have: du_signed  out  1  signed mode to the divider.
REQ-012 SHALL have: du_x, du_y  out  32 each  latched operands to the divider.
REQ-013 SHALL have: du_s, du_r  in  32 each  quotient and remainder from the divider.
REQ-014 SHALL have: du_done  in  1  divider result valid.
REQ-015 SHALL have: hi_we, lo_we  out  1 each  HI/LO write strobes.
REQ-016 SHALL have: hi_wdata, lo_wdata  out  32 each  HI gets the remainder, LO gets the quotient.
REQ-017 SHALL have: busy  out  1  state is not IDLE.
REQ-018 SHALL have: err  out  1  sticky timeout flag.

Function
REQ-019 SHALL implement the states IDLE, RUN, DRAIN and WB.
REQ-020 SHALL define start as ex_valid & (ex_div_op==01 | ex_div_op==10) & !ex_flush, evaluated only in IDLE.
REQ-021 SHALL, on start at cycle T, latch ex_x, ex_y and signedness at T and enter RUN at T+1.
REQ-022 SHALL assert du_go registered from T+1.
REQ-023 SHALL keep du_go high in RUN and DRAIN, through and including the du_done cycle, and low otherwise.
REQ-024 SHALL ensure du_go is low for at least one cycle between operations.
REQ-025 SHALL drive ex_stall combinationally: (IDLE & start) | RUN | (DRAIN & ex_valid & (ex_div_op!=00 | ex_hilo_rd)); WB drives 0.
REQ-026 SHALL, when du_done=1 in RUN, capture du_s into the LO register and du_r into the HI register, then go to WB.
REQ-027 SHALL, in WB, assert hi_we=lo_we=1 for exactly one cycle with the captured data, then go to IDLE.
REQ-028 SHALL, on ex_flush in RUN, go to DRAIN; the result is discarded and no HI/LO write occurs.
REQ-029 SHALL ignore ex_flush in DRAIN.
REQ-030 SHALL leave DRAIN for IDLE on du_done.
REQ-031 SHALL, on ex_flush in WB, suppress hi_we/lo_we; the state still returns to IDLE.
REQ-032 SHALL not start when ex_flush coincides with a DIV in IDLE; ex_stall is 0 in that case.
REQ-033 SHALL not accept a new DIV in WB; it is evaluated in the next IDLE cycle.
REQ-034 SHALL count cycles in RUN/DRAIN with a counter that clears on entry.
REQ-035 SHALL, when the counter reaches TIMEOUT without du_done, set err=1 (sticky until reset), drop du_go, write nothing and go to IDLE.
REQ-036 SHALL not special-case divide-by-zero: write back whatever the divider returns and raise no trap.
REQ-037 SHALL never let du_done outside RUN/DRAIN change state or outputs.

Reset
REQ-038 SHALL, on reset=1 at a clock edge and in any state, enter IDLE.
REQ-039 SHALL reset du_go, hi_we, lo_we, busy and err to 0.
REQ-040 SHALL reset du_x, du_y, hi_wdata, lo_wdata and the timeout counter to 0.
REQ-041 SHALL rely on the divider sharing the same reset (inverted) so that a mid-operation reset aborts both.

Structure
REQ-042 SHALL place the state encoding, the ex_div_op codes and the TIMEOUT default in the shared CPU package.
REQ-043 SHALL contain no sub-module; the divider is instantiated beside div_ctrl in the EX stage.

Verification
REQ-044 SHALL cover: DIV x=0xFFFFFFF9 (-7), y=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, single we pulse, ex_stall low only in WB.
REQ-045 SHALL cover: DIVU x=0xFFFFFFFF, y=0x10 -> LO=0x0FFFFFFF, HI=0x0000000F, du_signed=0.
REQ-046 SHALL cover: flush 10 cycles into RUN -> DRAIN, du_go held until du_done, no we; MFHI presented in DRAIN -> stalled until IDLE.
REQ-047 SHALL cover: du_done held low for 40 RUN cycles -> err=1, IDLE, du_go=0, no we; next DIV completes normally.
REQ-048 SHALL cover: reset pulsed mid-RUN -> next cycle IDLE with all outputs 0; DIV 100/7 afterwards -> LO=14, HI=2.
